// File: rtl/master_arb_port_if.sv
// Core-side request/grant signals and serial arbiter lines
// for one bus master port.
interface master_arb_port_if #(
  parameter int S_ID_WIDTH = 2
);
  logic                  req;
  logic [S_ID_WIDTH-1:0] slave_id;
  logic                  done;
  logic                  arb_tx;
  logic                  arb_rx;
  logic                  grant;
  logic                  busy;
  logic                  rejected;
  logic                  preempted;
  logic                  timeout_err;

  modport slave (
    input  req, slave_id, done, arb_rx,
    output arb_tx, grant, busy,
    output rejected, preempted, timeout_err
  );

  modport master (
    output req, slave_id, done, arb_rx,
    input  arb_tx, grant, busy,
    input  rejected, preempted, timeout_err
  );
endinterface

// File: rtl/master_arb_port.sv
// Master-side serial arbitration port: sends a request frame,
// decodes the arbiter reply and holds the bus while granted.
module master_arb_port #(
  parameter int NO_SLAVES   = 3,
  parameter int S_ID_WIDTH  = $clog2(NO_SLAVES+1),
  parameter int ACK_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  master_arb_port_if.slave bus
);
  localparam int BW = $clog2(S_ID_WIDTH+3)+1;
  localparam int TW = $clog2(ACK_TIMEOUT)+1;

  localparam logic [BW-1:0] LAST_START = BW'(2);
  localparam logic [BW-1:0] LAST_SID   = BW'(S_ID_WIDTH-1);
  localparam logic [TW-1:0] LAST_TMO   = TW'(ACK_TIMEOUT-1);

  typedef enum logic [2:0] {
    IDLE, START, SID, WAIT_ACK,
    RX_CODE, COM, OVER
  } state_e;

  state_e                state_q;
  logic [BW-1:0]         cnt_q;
  logic [TW-1:0]         tmo_q;
  logic [S_ID_WIDTH-1:0] id_q;
  logic [S_ID_WIDTH-1:0] sh_q;
  logic                  b1_q;
  logic                  tx_q;
  logic                  grant_q;
  logic                  busy_q;
  logic                  rej_q;
  logic                  pre_q;
  logic                  tmo_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      id_q      <= '0;
      sh_q      <= '0;
      b1_q      <= 1'b0;
      tx_q      <= 1'b0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      rej_q     <= 1'b0;
      pre_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      rej_q     <= 1'b0;
      pre_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            state_q <= START;
            id_q    <= bus.slave_id;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == LAST_START) begin
            state_q <= SID;
            cnt_q   <= '0;
            tx_q    <= id_q[S_ID_WIDTH-1];
            sh_q    <= id_q << 1;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
        SID: begin
          if (cnt_q == LAST_SID) begin
            state_q <= WAIT_ACK;
            tx_q    <= 1'b0;
            tmo_q   <= '0;
          end else begin
            cnt_q <= cnt_q + BW'(1);
            tx_q  <= sh_q[S_ID_WIDTH-1];
            sh_q  <= sh_q << 1;
          end
        end
        WAIT_ACK: begin
          if (bus.arb_rx) begin
            state_q <= RX_CODE;
            cnt_q   <= '0;
          end else if (tmo_q == LAST_TMO) begin
            state_q   <= IDLE;
            tmo_err_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        // First cycle captures b1; second decodes {b1,b0}.
        RX_CODE: begin
          if (cnt_q == '0) begin
            b1_q  <= bus.arb_rx;
            cnt_q <= BW'(1);
          end else begin
            unique case (1'b1)
              b1_q && bus.arb_rx: begin
                state_q <= COM;
                grant_q <= 1'b1;
                tx_q    <= 1'b1;
                cnt_q   <= '0;
              end
              b1_q && !bus.arb_rx: begin
                state_q <= IDLE;
                rej_q   <= 1'b1;
                busy_q  <= 1'b0;
              end
              default: state_q <= WAIT_ACK;
            endcase
          end
        end
        // done wins over a preempt code landing the same cycle.
        COM: begin
          if (bus.done) begin
            state_q <= OVER;
            tx_q    <= 1'b0;
            grant_q <= 1'b0;
          end else if (cnt_q == '0) begin
            if (bus.arb_rx) cnt_q <= BW'(1);
          end else if (cnt_q == BW'(1)) begin
            b1_q  <= bus.arb_rx;
            cnt_q <= BW'(2);
          end else begin
            cnt_q <= '0;
            if (!b1_q && bus.arb_rx) begin
              state_q <= OVER;
              pre_q   <= 1'b1;
              tx_q    <= 1'b0;
              grant_q <= 1'b0;
            end
          end
        end
        OVER: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b0;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.arb_tx      = tx_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.rejected    = rej_q;
  assign bus.preempted   = pre_q;
  assign bus.timeout_err = tmo_err_q;
endmodule

// File: doc/master_arb_port.md
MASTER_ARB_PORT -- requirements
Module: master_arb_port

Interface
REQ-001 SHALL have parameter NO_SLAVES, default 3: number of bus slaves.
REQ-002 SHALL have parameter S_ID_WIDTH, default $clog2(NO_SLAVES+1): slave-id field width.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16: WAIT_ACK cycles before abort.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  1: master core requests bus; sampled in IDLE only.
REQ-007 SHALL have port slave_id  input  S_ID_WIDTH: target slave; latched when req is accepted.
REQ-008 SHALL have port done  input  1: master core releases bus; honoured in COM only.
REQ-009 SHALL have port arb_tx  output  1: serial line to the arbiter's port_in for this master.
REQ-010 SHALL have port arb_rx  input  1: serial line from the arbiter's port_out for this master.
REQ-011 SHALL have port grant  output  1: high while this master owns the bus (state COM).
REQ-012 SHALL have port busy  output  1: high in every state except IDLE.
REQ-013 SHALL have port rejected  output  1: one-cycle pulse on a reject response.
REQ-014 SHALL have port preempted  output  1: one-cycle pulse on a preempt release.
REQ-015 SHALL have port timeout_err  output  1: one-cycle pulse on ACK timeout.

Function
REQ-016 SHALL implement FSM states IDLE, START, SID, WAIT_ACK, RX_CODE, COM, OVER; all outputs registered.
REQ-017 IDLE: arb_tx=0; on req=1 SHALL latch slave_id and go to START.
REQ-018 START: SHALL drive arb_tx=1 for exactly 3 cycles, then go to SID.
REQ-019 SID: SHALL drive the latched id MSB-first, one bit per cycle for S_ID_WIDTH cycles, then go to WAIT_ACK.
REQ-020 Latency: req accepted at edge k SHALL give arb_tx=1 in cycles k+1..k+3 and id bits in cycles k+4..k+3+S_ID_WIDTH.
REQ-021 WAIT_ACK: arb_tx=0; arb_rx=1 SHALL be taken as the frame start bit and go to RX_CODE.
REQ-022 WAIT_ACK: a counter SHALL abort after ACK_TIMEOUT cycles without a start bit; pulse timeout_err and return to IDLE; the counter SHALL clear on entry to WAIT_ACK.
REQ-023 RX_CODE: SHALL shift in the next 2 arb_rx bits (b1 then b0); arb_tx=0.
REQ-024 Code 11 SHALL go to COM; code 10 SHALL pulse rejected and go to IDLE; codes 00 and 01 SHALL return to WAIT_ACK without resetting the timeout counter.
REQ-025 COM: grant=1 and arb_tx=1 held continuously.
REQ-026 COM: done=1 SHALL go to OVER.
REQ-027 COM: an arb_rx frame of start bit plus code 01 SHALL pulse preempted and go to OVER; frames with other codes are ignored.
REQ-028 OVER: SHALL drive arb_tx=0 for exactly 1 cycle with grant=0, then go to IDLE.
REQ-029 In COM, done=1 in the same cycle as the final preempt code bit SHALL be treated as a normal release, with no preempted pulse.
REQ-030 req while busy=1 SHALL be ignored; it is not queued.
REQ-031 A new req is accepted in the first IDLE cycle after OVER, rejection or timeout (minimum 1 IDLE cycle).
REQ-032 At most one of rejected, preempted or timeout_err SHALL be high in any cycle.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, with arb_tx=0, grant=0, busy=0, rejected=0, preempted=0, timeout_err=0, all counters 0 and the latched id 0.
REQ-034 rst asserted mid-frame or mid-COM SHALL abort without emitting OVER; the first cycle after release is IDLE.

Verification
REQ-035 Grant: S_ID_WIDTH=2, req with slave_id=2'b10; arb_rx=1,1,1 two cycles after SID ends -> arb_tx 1,1,1,1,0 then 0s; grant=1 one cycle after the last code bit; done -> one arb_tx=0 cycle, then IDLE.
REQ-036 Reject: arb_rx=1,1,0 -> rejected pulses once, busy=0 the next cycle, grant never high.
REQ-037 Timeout: ACK_TIMEOUT=16, arb_rx held 0 -> timeout_err pulses exactly 16 cycles after WAIT_ACK entry; then IDLE.
REQ-038 Preempt: in COM, arb_rx=1,0,1 -> preempted pulse, arb_tx=0 for one cycle, grant=0; the same frame with done coincident on the last bit -> no preempted pulse.
REQ-039 Reset/ignore: req pulsed during SID -> frame unchanged; rst during COM -> arb_tx=0 and grant=0 asynchronously, next req restarts with 3 start bits.
